// File: rtl/lsu_pkg.sv
// Shared types and funct3 encodings for the load/store unit.
// No logic of its own; zero latency.
// No flow control; constants and types only.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, lane extraction/extension for loads, access legality.
// Purely combinational, zero latency.
// No flow control; the parent decides when outputs are used.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        we,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_st,
  output logic [31:0] rdata_ext,
  output logic        misaligned,
  output logic        illegal
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Request decode: byte enables, replicated store data, legality and alignment.
  always_comb begin
    be         = 4'b0000;
    wdata_st   = wdata;
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        be       = 4'b0001 << addr_lo;
        wdata_st = {4{wdata[7:0]}};
      end
      2'b01: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_st   = {2{wdata[15:0]}};
        misaligned = addr_lo[0];
      end
      2'b10: begin
        be         = 4'b1111;
        misaligned = (addr_lo != 2'b00);
      end
      default: begin
        be = 4'b0000;
      end
    endcase
    // Stores only have B/H/W; loads additionally have BU/HU.
    if (we) illegal = funct3[2] | (funct3[1:0] == 2'b11);
    else    illegal = (funct3 == 3'b011) | (funct3[2:1] == 2'b11);
  end

  // Load path: pick the addressed lane from the returned word and extend it.
  always_comb begin
    case (ld_addr_lo)
      2'd0:    w_byte = rdata[7:0];
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      default: w_byte = rdata[31:24];
    endcase
    w_half = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (ld_funct3)
      F3_B:    rdata_ext = {{24{w_byte[7]}}, w_byte};
      F3_BU:   rdata_ext = {24'h000000, w_byte};
      F3_H:    rdata_ext = {{16{w_half[15]}}, w_half};
      F3_HU:   rdata_ext = {16'h0000, w_half};
      default: rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: RV32I loads/stores over a req/gnt/rvalid data bus with lane steering and timeout.
// Latency from accept with zero-wait memory: store 2, load 3, misaligned/illegal 1 cycle.
// lsu_ready low from accept until the done pulse; dmem_req held until dmem_gnt or timeout.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic        lsu_we,
  input  logic [2:0]  lsu_funct3,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_done,
  output logic [31:0] lsu_rdata,
  output logic        lsu_misaligned,
  output logic        lsu_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  lsu_state_t  r_state;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_mis;
  logic [15:0] r_cnt;

  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_rdata_ext;
  logic        w_misaligned;
  logic        w_illegal;
  logic        w_timeout;

  lsu_align u_align (
    .funct3     (lsu_funct3),
    .we         (lsu_we),
    .addr_lo    (lsu_addr[1:0]),
    .wdata      (lsu_wdata),
    .ld_funct3  (r_funct3),
    .ld_addr_lo (r_addr[1:0]),
    .rdata      (dmem_rdata),
    .be         (w_be),
    .wdata_st   (w_wdata),
    .rdata_ext  (w_rdata_ext),
    .misaligned (w_misaligned),
    .illegal    (w_illegal)
  );

  assign w_timeout = (r_cnt == 16'(TIMEOUT_CYCLES - 1));

  // Access sequencer: capture at accept, run the bus handshake, abort a stalled phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_be     <= 4'b0000;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_mis    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (lsu_valid) begin
            r_we     <= lsu_we;
            r_funct3 <= lsu_funct3;
            r_addr   <= lsu_addr;
            r_be     <= w_be;
            r_wdata  <= w_wdata;
            r_err    <= w_illegal;
            r_mis    <= w_misaligned & ~w_illegal;
            r_cnt    <= '0;
            if (w_illegal | w_misaligned) begin
              // Rejected without touching the bus.
              r_rdata <= '0;
              r_state <= RESP;
            end else begin
              r_state <= REQ;
            end
          end
        end
        REQ: begin
          // rvalid is not looked at here: no load can be outstanding yet.
          if (dmem_gnt) begin
            r_cnt <= '0;
            if (r_we) begin
              r_rdata <= '0;
              r_state <= RESP;
            end else begin
              r_state <= WAIT;
            end
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        WAIT: begin
          if (dmem_rvalid) begin
            r_rdata <= w_rdata_ext;
            r_state <= RESP;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Decoded from state so that an async reset drops dmem_req and raises lsu_ready at once.
  assign lsu_ready      = (r_state == IDLE);
  assign lsu_done       = (r_state == RESP);
  assign lsu_err        = lsu_done & r_err;
  assign lsu_misaligned = lsu_done & r_mis;
  assign lsu_rdata      = r_rdata;
  assign dmem_req       = (r_state == REQ);
  assign dmem_we        = r_we;
  assign dmem_addr      = {r_addr[31:2], 2'b00};
  assign dmem_be        = r_be;
  assign dmem_wdata     = r_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed spec cases plus randomized accesses vs a model.
// Memory responder is driven from the bench with configurable gnt/rvalid delays.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lsu_valid, lsu_ready, lsu_we;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic        lsu_done, lsu_misaligned, lsu_err;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_we(lsu_we), .lsu_funct3(lsu_funct3),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
    .lsu_misaligned(lsu_misaligned), .lsu_err(lsu_err),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  // Observations from the most recent access.
  int          o_done_cyc, o_req_cyc;
  logic [31:0] o_addr, o_wdata, o_rdata;
  logic [3:0]  o_be;
  logic        o_we, o_err, o_mis, o_ready0, o_busy_ready;

  // Issue one access in cycle 0 and play memory until lsu_done or 40 cycles.
  task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] mem_word,
                           input int gnt_dly, input int rv_dly,
                           input bit no_gnt, input bit no_rv, input bit noise);
    int req_n;
    int gnt_cyc;
    req_n = 0; gnt_cyc = -1;
    o_done_cyc = -1; o_busy_ready = 1'b0;
    o_addr = '0; o_wdata = '0; o_be = '0; o_we = 1'b0; o_rdata = '0; o_err = 1'b0; o_mis = 1'b0;
    @(negedge clk);
    o_ready0   = lsu_ready;
    lsu_valid  = 1'b1; lsu_we = we; lsu_funct3 = f3; lsu_addr = addr; lsu_wdata = wdata;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = $urandom;
      if (noise) begin
        lsu_valid = 1'b1; lsu_we = 1'($urandom); lsu_funct3 = 3'($urandom);
        lsu_addr = $urandom; lsu_wdata = $urandom;
      end else begin
        lsu_valid = 1'b0;
      end
      if (lsu_ready) o_busy_ready = 1'b1;
      if (lsu_done) begin
        o_done_cyc = k; o_rdata = lsu_rdata; o_err = lsu_err; o_mis = lsu_misaligned;
        lsu_valid = 1'b0;
        break;
      end
      if (dmem_req) begin
        o_addr = dmem_addr; o_be = dmem_be; o_wdata = dmem_wdata; o_we = dmem_we;
        if (!no_gnt && req_n == gnt_dly) begin
          dmem_gnt = 1'b1; gnt_cyc = k;
        end else if (noise) begin
          dmem_rvalid = 1'b1;
        end
        req_n++;
      end else if (gnt_cyc >= 0 && !no_rv && k == gnt_cyc + 1 + rv_dly) begin
        dmem_rvalid = 1'b1; dmem_rdata = mem_word;
      end
    end
    o_req_cyc = req_n;
  endtask

  // Reference: what an RV32I access should look like on the bus and at the result port.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] mem_word,
                                output bit ill, output bit mis, output logic [3:0] be,
                                output logic [31:0] wd, output logic [31:0] rd);
    int          size;
    int          off;
    logic [31:0] mask;
    size = 1 << f3[1:0];
    off  = int'(addr[1:0]);
    ill  = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    mis  = !ill && ((off % size) != 0);
    be   = 4'((1 << size) - 1) << off;
    wd   = (size == 1) ? wdata[7:0] * 32'h01010101 : (size == 2) ? wdata[15:0] * 32'h00010001 : wdata;
    mask = (size >= 4) ? 32'hFFFFFFFF : (32'd1 << (8 * size)) - 32'd1;
    rd   = (mem_word >> (8 * off)) & mask;
    if (!f3[2] && size < 4 && rd[8 * size - 1]) rd = rd | ~mask;
  endfunction

  task automatic test_reset;
    #2;
    n_tests++; if (lsu_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b want 1", lsu_ready); end
    n_tests++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b want 0", dmem_req); end
    n_tests++; if (lsu_done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b want 0", lsu_done); end
    n_tests++; if (lsu_err !== 1'b0 || lsu_misaligned !== 1'b0) begin n_fail++; $display("FAIL rst_flags got err=%b mis=%b want 0 0", lsu_err, lsu_misaligned); end
    n_tests++; if (lsu_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got %h want 0", lsu_rdata); end
    n_tests++; if ({dmem_we, dmem_be, dmem_addr, dmem_wdata} !== '0) begin n_fail++; $display("FAIL rst_bus got we=%b be=%b addr=%h wdata=%h want all 0", dmem_we, dmem_be, dmem_addr, dmem_wdata); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_store_lanes;
    do_access(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 0, 0, 0);
    n_tests++; if (o_done_cyc != 2) begin n_fail++; $display("FAIL sw_latency got %0d want 2", o_done_cyc); end
    n_tests++; if (o_addr !== 32'h100 || o_be !== 4'b1111 || o_we !== 1'b1) begin n_fail++; $display("FAIL sw_bus got addr=%h be=%b we=%b want 100 1111 1", o_addr, o_be, o_we); end
    n_tests++; if (o_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_wdata got %h want deadbeef", o_wdata); end
    n_tests++; if (o_err !== 1'b0 || o_rdata !== 32'h0) begin n_fail++; $display("FAIL sw_resp got err=%b rdata=%h want 0 0", o_err, o_rdata); end
    do_access(1'b1, 3'b000, 32'h103, 32'h000000AB, 32'h0, 0, 0, 0, 0, 0);
    n_tests++; if (o_be !== 4'b1000 || o_wdata !== 32'hABABABAB) begin n_fail++; $display("FAIL sb_lane got be=%b wdata=%h want 1000 abababab", o_be, o_wdata); end
    do_access(1'b1, 3'b001, 32'h102, 32'h00001234, 32'h0, 0, 0, 0, 0, 0);
    n_tests++; if (o_be !== 4'b1100 || o_wdata !== 32'h12341234) begin n_fail++; $display("FAIL sh_lane got be=%b wdata=%h want 1100 12341234", o_be, o_wdata); end
  endtask

  task automatic test_load_extend;
    do_access(1'b0, 3'b000, 32'h102, 32'h0, 32'h12803456, 0, 0, 0, 0, 0);
    n_tests++; if (o_done_cyc != 3) begin n_fail++; $display("FAIL lb_latency got %0d want 3", o_done_cyc); end
    n_tests++; if (o_addr !== 32'h100 || o_be !== 4'b0100 || o_we !== 1'b0) begin n_fail++; $display("FAIL lb_bus got addr=%h be=%b we=%b want 100 0100 0", o_addr, o_be, o_we); end
    n_tests++; if (o_rdata !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_sext got %h want ffffff80", o_rdata); end
    do_access(1'b0, 3'b100, 32'h102, 32'h0, 32'h12803456, 0, 0, 0, 0, 0);
    n_tests++; if (o_rdata !== 32'h00000080) begin n_fail++; $display("FAIL lbu_zext got %h want 00000080", o_rdata); end
    do_access(1'b0, 3'b101, 32'h102, 32'h0, 32'h12803456, 0, 0, 0, 0, 0);
    n_tests++; if (o_rdata !== 32'h00001280) begin n_fail++; $display("FAIL lhu_zext got %h want 00001280", o_rdata); end
  endtask

  task automatic test_misaligned_illegal;
    do_access(1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 0, 0, 0, 0, 0);
    n_tests++; if (o_req_cyc != 0) begin n_fail++; $display("FAIL lh_mis_noreq got %0d req cycles want 0", o_req_cyc); end
    n_tests++; if (o_done_cyc != 1 || o_mis !== 1'b1 || o_err !== 1'b0) begin n_fail++; $display("FAIL lh_mis_resp got cyc=%0d mis=%b err=%b want 1 1 0", o_done_cyc, o_mis, o_err); end
    do_access(1'b0, 3'b011, 32'h200, 32'h0, 32'h0, 0, 0, 0, 0, 0);
    n_tests++; if (o_req_cyc != 0 || o_done_cyc != 1 || o_err !== 1'b1 || o_mis !== 1'b0) begin n_fail++; $display("FAIL ld011_err got req=%0d cyc=%0d err=%b mis=%b want 0 1 1 0", o_req_cyc, o_done_cyc, o_err, o_mis); end
    do_access(1'b1, 3'b100, 32'h200, 32'h0, 32'h0, 0, 0, 0, 0, 0);
    n_tests++; if (o_req_cyc != 0 || o_err !== 1'b1) begin n_fail++; $display("FAIL st100_err got req=%0d err=%b want 0 1", o_req_cyc, o_err); end
  endtask

  task automatic test_timeout;
    do_access(1'b1, 3'b010, 32'h300, 32'h11223344, 32'h0, 0, 0, 1, 0, 0);
    n_tests++; if (o_req_cyc != 8) begin n_fail++; $display("FAIL to_req_cycles got %0d want 8", o_req_cyc); end
    n_tests++; if (o_done_cyc != 9 || o_err !== 1'b1) begin n_fail++; $display("FAIL to_req_resp got cyc=%0d err=%b want 9 1", o_done_cyc, o_err); end
    do_access(1'b0, 3'b010, 32'h304, 32'h0, 32'hA5A5F00D, 0, 0, 0, 0, 0);
    n_tests++; if (o_rdata !== 32'hA5A5F00D) begin n_fail++; $display("FAIL to_prior_lw got %h want a5a5f00d", o_rdata); end
    do_access(1'b0, 3'b010, 32'h304, 32'h0, 32'h0, 1, 0, 0, 1, 0);
    n_tests++; if (o_done_cyc != 11 || o_err !== 1'b1 || o_rdata !== 32'h0) begin n_fail++; $display("FAIL to_wait got cyc=%0d err=%b rdata=%h want 11 1 0", o_done_cyc, o_err, o_rdata); end
  endtask

  task automatic test_random;
    logic we; logic [2:0] f3; logic [31:0] addr, wd, mw, e_wd, e_rd; logic [3:0] e_be;
    bit ill, mis, bad; int gd, rvd, e_cyc; bit nz;
    for (int i = 0; i < 60; i++) begin
      we = 1'($urandom); f3 = 3'($urandom_range(0, 7)); addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      wd = $urandom; mw = $urandom; gd = $urandom_range(0, 5); rvd = $urandom_range(0, 5);
      nz = 1'($urandom);
      do_access(we, f3, addr, wd, mw, gd, rvd, 0, 0, nz);
      model(we, f3, addr, wd, mw, ill, mis, e_be, e_wd, e_rd);
      bad   = ill || mis;
      e_cyc = bad ? 1 : (we ? gd + 2 : gd + rvd + 3);
      n_tests++; if (o_ready0 !== 1'b1 || o_busy_ready !== 1'b0) begin n_fail++; $display("FAIL rnd_ready i=%0d got idle=%b busy=%b want 1 0", i, o_ready0, o_busy_ready); end
      n_tests++; if (o_done_cyc != e_cyc) begin n_fail++; $display("FAIL rnd_latency i=%0d got %0d want %0d", i, o_done_cyc, e_cyc); end
      n_tests++; if (o_err !== ill || o_mis !== mis) begin n_fail++; $display("FAIL rnd_flags i=%0d got err=%b mis=%b want %b %b", i, o_err, o_mis, ill, mis); end
      n_tests++; if (o_req_cyc != (bad ? 0 : gd + 1)) begin n_fail++; $display("FAIL rnd_req i=%0d got %0d want %0d", i, o_req_cyc, bad ? 0 : gd + 1); end
      if (!bad) begin
        n_tests++; if (o_addr !== {addr[31:2], 2'b00} || o_be !== e_be || o_we !== we) begin n_fail++; $display("FAIL rnd_bus i=%0d got addr=%h be=%b we=%b want %h %b %b", i, o_addr, o_be, o_we, {addr[31:2], 2'b00}, e_be, we); end
        if (we) begin
          n_tests++; if (o_wdata !== e_wd) begin n_fail++; $display("FAIL rnd_wdata i=%0d got %h want %h", i, o_wdata, e_wd); end
        end
        n_tests++; if (o_rdata !== (we ? 32'h0 : e_rd)) begin n_fail++; $display("FAIL rnd_rdata i=%0d got %h want %h", i, o_rdata, we ? 32'h0 : e_rd); end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] x, a, e_wd, e_rd; logic [2:0] f3; logic [3:0] e_be; bit ill, mis;
    for (int i = 0; i < 8; i++) begin
      x = $urandom; a = $urandom & 32'hFFFFFFFC;
      do_access(1'b1, 3'b010, a, x, 32'h0, 0, 0, 0, 0, 1);
      n_tests++; if (o_done_cyc != 2 || o_wdata !== x) begin n_fail++; $display("FAIL b2b_sw i=%0d got cyc=%0d wdata=%h want 2 %h", i, o_done_cyc, o_wdata, x); end
      f3 = (i % 2 == 0) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(4, 5));
      a[1:0] = (f3[1:0] == 2'b00) ? 2'($urandom) : (f3[1:0] == 2'b01) ? {1'($urandom), 1'b0} : 2'b00;
      model(1'b0, f3, a, 32'h0, x, ill, mis, e_be, e_wd, e_rd);
      do_access(1'b0, f3, a, 32'h0, x, 0, 0, 0, 0, 1);
      n_tests++; if (o_done_cyc != 3 || o_rdata !== e_rd) begin n_fail++; $display("FAIL b2b_ld i=%0d f3=%0d got cyc=%0d rdata=%h want 3 %h", i, f3, o_done_cyc, o_rdata, e_rd); end
    end
  endtask

  task automatic test_reset_mid_access;
    bit seen_done;
    // Reset while the request is outstanding.
    @(negedge clk);
    lsu_valid = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'b010; lsu_addr = 32'h40;
    @(negedge clk);
    lsu_valid = 1'b0;
    n_tests++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL mid_req_pre got %b want 1", dmem_req); end
    rst_n = 1'b0; #1;
    n_tests++; if (dmem_req !== 1'b0 || lsu_ready !== 1'b1) begin n_fail++; $display("FAIL mid_req_rst got req=%b ready=%b want 0 1", dmem_req, lsu_ready); end
    @(negedge clk); rst_n = 1'b1;
    // Reset while waiting for load data, then a late rvalid.
    @(negedge clk);
    lsu_valid = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'b010; lsu_addr = 32'h44;
    @(negedge clk);
    lsu_valid = 1'b0; dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    rst_n = 1'b0; #1;
    n_tests++; if (dmem_req !== 1'b0 || lsu_ready !== 1'b1 || lsu_done !== 1'b0) begin n_fail++; $display("FAIL mid_wait_rst got req=%b ready=%b done=%b want 0 1 0", dmem_req, lsu_ready, lsu_done); end
    @(negedge clk); rst_n = 1'b1;
    seen_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D;
      if (lsu_done) seen_done = 1'b1;
    end
    @(negedge clk);
    dmem_rvalid = 1'b0;
    if (lsu_done) seen_done = 1'b1;
    n_tests++; if (seen_done !== 1'b0 || lsu_rdata !== 32'h0) begin n_fail++; $display("FAIL late_rvalid got done_seen=%b rdata=%h want 0 0", seen_done, lsu_rdata); end
    do_access(1'b1, 3'b010, 32'h48, 32'h0BADCAFE, 32'h0, 0, 0, 0, 0, 0);
    n_tests++; if (o_done_cyc != 2 || o_wdata !== 32'h0BADCAFE) begin n_fail++; $display("FAIL post_rst_sw got cyc=%0d wdata=%h want 2 0badcafe", o_done_cyc, o_wdata); end
  endtask

  initial begin
    rst_n = 1'b0; lsu_valid = 1'b0; lsu_we = 1'b0; lsu_funct3 = 3'b000;
    lsu_addr = '0; lsu_wdata = '0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    test_reset;
    test_store_lanes;
    test_load_extend;
    test_misaligned_illegal;
    test_timeout;
    test_random;
    test_back_to_back;
    test_reset_mid_access;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
